pipe_stage: RTL
===============

PIPE_STAGE -- requirements
Module: pipe_stage

Interface
REQ-001 Parameter CTRL_WIDTH, default 16: width of control payload, zeroed on bubble/flush.
REQ-002 Parameter DATA_WIDTH, default 32: width of data payload, not zeroed on bubble.
REQ-003 Parameter CNT_WIDTH, default 16: width of the stall counter.
REQ-004 clk  in  1  sole clock, all state updates on rising edge.
REQ-005 rst_n  in  1  reset, synchronous, active-low.
REQ-006 flush  in  1  kill stage contents at next edge.
REQ-007 in_valid  in  1  upstream payload valid.
REQ-008 in_ready  out  1  stage can accept; a transfer occurs when in_valid && in_ready at a rising edge.
REQ-009 in_ctrl  in  CTRL_WIDTH  upstream control fields.
REQ-010 in_data  in  DATA_WIDTH  upstream data fields.
REQ-011 out_valid  out  1  stage holds a live entry.
REQ-012 out_ready  in  1  downstream accepts; a transfer occurs when out_valid && out_ready at a rising edge.
REQ-013 out_ctrl  out  CTRL_WIDTH  registered control.
REQ-014 out_data  out  DATA_WIDTH  registered data.
REQ-015 stall_cnt  out  CNT_WIDTH  count of back-pressured cycles.

Function
REQ-016 The stage SHALL provide exactly one cycle of latency from input transfer to out_valid assertion when empty.
REQ-017 The stage SHALL drive out_ctrl to all-zero in every cycle in which out_valid is 0.
REQ-018 Stalled output (out_valid=1, out_ready=0) SHALL hold out_ctrl and out_data stable until transfer.
REQ-019 Simultaneous output and input transfers SHALL replace the entry with no bubble cycle.
REQ-020 Output transfer without input transfer SHALL make out_valid 0 at the next edge; out_data SHALL retain its last value.
REQ-021 flush=1 at an edge SHALL make out_valid 0, out_ctrl 0 and empty all internal storage, discarding any transfer accepted in that cycle.
REQ-022 Priority SHALL be: reset > flush > transfer.
REQ-023 stall_cnt SHALL increment by 1 each edge where out_valid && !out_ready, saturate at 2^CNT_WIDTH-1, and be unaffected by flush.
REQ-024 No payload SHALL be dropped or duplicated outside flush/reset.

Reset
REQ-025 With rst_n=0 at a rising edge: out_valid=0, out_ctrl=0, out_data=0, stall_cnt=0, skid storage empty.
REQ-026 in_ready SHALL be 1 in the first cycle after reset release.
REQ-027 Reset asserted mid-stall SHALL discard the held entry with no downstream transfer.

Configuration
REQ-028 Macro PIPE_STAGE_SKID_EN defined: one-entry skid register; in_ready SHALL be a flop output equal to "skid empty"; input transfer while main full and stalled SHALL load skid; output transfer with skid full SHALL move skid to main the same edge; full throughput, no combinational out_ready->in_ready path.
REQ-029 Macro PIPE_STAGE_SKID_EN undefined: no skid storage; in_ready SHALL equal out_ready || !out_valid combinationally.

Verification
REQ-030 Reset: rst_n=0 for 2 cycles with in_valid=1, in_ctrl=16'hFFFF -> out_valid=0, out_ctrl=0, stall_cnt=0; in_ready=1 after release.
REQ-031 Streaming: out_ready=1, 8 back-to-back inputs data 0..7 -> outputs 0..7 in order, one per cycle, first one cycle after first input.
REQ-032 Back-pressure: load data 32'hA5A5_0001, out_ready=0 for 5 cycles -> out_data stable, stall_cnt=5; with SKID_EN one more input 32'h0002 accepted then in_ready=0; release -> 0001 then 0002 delivered, none lost.
REQ-033 Flush: entry valid with in_ctrl=16'h00FF, flush=1 with concurrent in_valid=1 -> next cycle out_valid=0, out_ctrl=0, skid empty, stall_cnt unchanged.
REQ-034 Saturation: CNT_WIDTH=4, hold stall 20 cycles -> stall_cnt=15 and stays 15.
REQ-035 Priority: rst_n=0 and flush=1 together with valid entry -> reset values of REQ-025.

Source files
------------

// File: rtl/pipe_stage.sv
// Single-entry valid/ready pipeline register with stall counter.
// Define PIPE_STAGE_SKID_EN to add a one-entry skid buffer that registers in_ready.
module pipe_stage #(
  parameter int CTRL_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_WIDTH-1:0] in_ctrl,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_WIDTH-1:0] out_ctrl,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [CNT_WIDTH-1:0]  CNT_MAX   = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
  localparam logic [CTRL_WIDTH-1:0] CTRL_ZERO = {CTRL_WIDTH{1'b0}};
  localparam logic [DATA_WIDTH-1:0] DATA_ZERO = {DATA_WIDTH{1'b0}};

  logic                  main_valid_r;
  logic [CTRL_WIDTH-1:0] main_ctrl_r;
  logic [DATA_WIDTH-1:0] main_data_r;
  logic [CNT_WIDTH-1:0]  stall_cnt_r;

  logic                  main_valid_nxt_s;
  logic [CTRL_WIDTH-1:0] main_ctrl_nxt_s;
  logic [DATA_WIDTH-1:0] main_data_nxt_s;
  logic                  in_xfer_s;
  logic                  out_xfer_s;

`ifdef PIPE_STAGE_SKID_EN
  logic                  skid_valid_r;
  logic [CTRL_WIDTH-1:0] skid_ctrl_r;
  logic [DATA_WIDTH-1:0] skid_data_r;
  logic                  in_ready_r;

  logic                  skid_valid_nxt_s;
  logic [CTRL_WIDTH-1:0] skid_ctrl_nxt_s;
  logic [DATA_WIDTH-1:0] skid_data_nxt_s;

  assign in_ready = in_ready_r;
`else
  assign in_ready = out_ready || !main_valid_r;
`endif

  assign in_xfer_s  = in_valid && in_ready;
  assign out_xfer_s = main_valid_r && out_ready;

  assign out_valid = main_valid_r;
  assign out_ctrl  = main_ctrl_r;
  assign out_data  = main_data_r;
  assign stall_cnt = stall_cnt_r;

  // Next-state selection for the main (and skid) entries.
  always_comb begin
    main_valid_nxt_s = main_valid_r;
    main_ctrl_nxt_s  = main_ctrl_r;
    main_data_nxt_s  = main_data_r;
`ifdef PIPE_STAGE_SKID_EN
    skid_valid_nxt_s = skid_valid_r;
    skid_ctrl_nxt_s  = skid_ctrl_r;
    skid_data_nxt_s  = skid_data_r;
`endif
    if (flush) begin
      main_valid_nxt_s = 1'b0;
      main_ctrl_nxt_s  = CTRL_ZERO;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_nxt_s = 1'b0;
      skid_ctrl_nxt_s  = CTRL_ZERO;
`endif
    end else if (!main_valid_r || out_xfer_s) begin
      // Main slot frees up this edge; the skid entry is older than any new input.
`ifdef PIPE_STAGE_SKID_EN
      if (skid_valid_r) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = skid_ctrl_r;
        main_data_nxt_s  = skid_data_r;
        skid_valid_nxt_s = 1'b0;
        skid_ctrl_nxt_s  = CTRL_ZERO;
      end else if (in_xfer_s) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = in_ctrl;
        main_data_nxt_s  = in_data;
      end else begin
        main_valid_nxt_s = 1'b0;
        main_ctrl_nxt_s  = CTRL_ZERO;
      end
`else
      if (in_xfer_s) begin
        main_valid_nxt_s = 1'b1;
        main_ctrl_nxt_s  = in_ctrl;
        main_data_nxt_s  = in_data;
      end else begin
        main_valid_nxt_s = 1'b0;
        main_ctrl_nxt_s  = CTRL_ZERO;
      end
`endif
    end else begin
`ifdef PIPE_STAGE_SKID_EN
      if (in_xfer_s) begin
        skid_valid_nxt_s = 1'b1;
        skid_ctrl_nxt_s  = in_ctrl;
        skid_data_nxt_s  = in_data;
      end else begin
        skid_valid_nxt_s = skid_valid_r;
      end
`else
      main_valid_nxt_s = main_valid_r;
`endif
    end
  end

  // Payload storage registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      main_valid_r <= 1'b0;
      main_ctrl_r  <= CTRL_ZERO;
      main_data_r  <= DATA_ZERO;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_r <= 1'b0;
      skid_ctrl_r  <= CTRL_ZERO;
      skid_data_r  <= DATA_ZERO;
      in_ready_r   <= 1'b1;
`endif
    end else begin
      main_valid_r <= main_valid_nxt_s;
      main_ctrl_r  <= main_ctrl_nxt_s;
      main_data_r  <= main_data_nxt_s;
`ifdef PIPE_STAGE_SKID_EN
      skid_valid_r <= skid_valid_nxt_s;
      skid_ctrl_r  <= skid_ctrl_nxt_s;
      skid_data_r  <= skid_data_nxt_s;
      in_ready_r   <= !skid_valid_nxt_s;
`endif
    end
  end

  // Saturating back-pressure counter; flush deliberately does not touch it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stall_cnt_r <= {CNT_WIDTH{1'b0}};
    end else if (main_valid_r && !out_ready && (stall_cnt_r != CNT_MAX)) begin
      stall_cnt_r <= stall_cnt_r + CNT_ONE;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

endmodule
